// File: rtl/apb_reg_slave.sv
// APB completer with a bank of word-aligned RW registers, a read-only
// write-count register in the top slot, a fixed number of PREADY wait states
// per access, and address/access error reporting on PSLVERR.
//
// Handshake: a transfer is one SETUP cycle (PSEL=1, PENABLE=0) followed by
// ACCESS cycles (PSEL=1, PENABLE=1). The transfer completes on the single
// cycle in which PREADY=1. PRDATA and PSLVERR are meaningful only in that
// cycle and are driven to 0 in every other cycle. Dropping PSEL before
// PREADY aborts the transfer without side effects.
module apb_reg_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [3:0]       WS      = 4'(WAIT_STATES);
    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [IDX_W-1:0]      idx;
    logic                  addr_hit;
    logic                  access_err;
    logic                  acc_phase;
    logic                  xfer_done;
    logic                  wr_commit;

    // Address decode: word index plus checks for alignment and upper bits.
    assign idx        = PADDR[2 +: IDX_W];
    assign addr_hit   = (PADDR[1:0] == 2'b00) && ((PADDR >> (2 + IDX_W)) == '0);
    assign access_err = !addr_hit || (PWRITE && (idx == CNT_IDX));

    // PSEL & PENABLE means we are either in ACCESS or entering it this cycle
    // (from SETUP normally, or straight from IDLE on a protocol slip).
    assign acc_phase  = PSEL && PENABLE;

    // Reset gates PREADY so a transfer straddling reset never completes.
    assign xfer_done  = !ARESET && acc_phase && (wait_cnt == WS);
    assign wr_commit  = xfer_done && PWRITE && !access_err;

    assign PREADY     = xfer_done;
    assign PSLVERR    = xfer_done && access_err;
    assign PRDATA     = (xfer_done && !access_err) ? regs[idx] : '0;

    // Next-state logic; IDLE decodes PSEL immediately so back-to-back
    // transfers lose no cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (PSEL && !PENABLE)
                    state_nxt = ST_SETUP;
                else if (acc_phase)
                    state_nxt = xfer_done ? ST_IDLE : ST_ACCESS;
            end
            ST_SETUP: begin
                if (!PSEL)
                    state_nxt = ST_IDLE;
                else if (PENABLE)
                    state_nxt = xfer_done ? ST_IDLE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (xfer_done || !PSEL)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Wait-state counter: counts access cycles, clears outside the access phase
    // and on completion.
    always_ff @(posedge ACLK) begin
        if (ARESET)
            wait_cnt <= '0;
        else if (acc_phase && (wait_cnt < WS))
            wait_cnt <= wait_cnt + 4'd1;
        else
            wait_cnt <= '0;
    end

    // Register bank: RW slots take PWDATA, the top slot counts committed writes.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_REGS - 1; i++)
                if (idx == IDX_W'(i))
                    regs[i] <= PWDATA;
            regs[NUM_REGS-1] <= regs[NUM_REGS-1] + 1'b1;
        end
    end

    // Flatten the register bank for the surrounding logic.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++)
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: three instances with WAIT_STATES = 1, 0 and 3 share
// one clock, each with its own APB signals and reset. A register-map model
// (array of words plus a write counter) predicts every response.
module tb_apb_reg_slave;

    logic        clk;
    logic        areset  [3];
    logic [31:0] paddr   [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [255:0] reg_out [3];

    logic [31:0] m_regs [3][8];

    int total;
    int bad;

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_reg_slave #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .NUM_REGS   (8),
            .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .ACLK   (clk),
            .ARESET (areset[g]),
            .PADDR  (paddr[g]),
            .PSEL   (psel[g]),
            .PENABLE(penable[g]),
            .PWRITE (pwrite[g]),
            .PWDATA (pwdata[g]),
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g]),
            .reg_out(reg_out[g])
        );
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    function automatic int ws_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // Error rules: misaligned, outside the 8-word window, or a write to the counter.
    function automatic bit exp_err(input logic [31:0] a, input bit w);
        return (a % 4 != 0) || (a >= 32) || (w && (a / 4 == 7));
    endfunction

    function automatic logic [255:0] m_flat(input int d);
        logic [255:0] f;
        for (int i = 0; i < 8; i++)
            f[i*32 +: 32] = m_regs[d][i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer starting on the next cycle (back-to-back capable).
    task automatic xfer(input int d, input logic [31:0] a, input bit w, input logic [31:0] wd);
        bit          seen;
        bit          e;
        logic [31:0] rd_exp;
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = w; pwdata[d] = wd;
        #1 chk("setup_pready", 256'(pready[d]), 256'(0));
        @(negedge clk);
        penable[d] = 1'b1;
        e      = exp_err(a, w);
        rd_exp = e ? 32'h0 : m_regs[d][a[4:2]];
        seen   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (pready[d]) begin
                seen = 1'b1;
                chk("latency", 256'(k), 256'(ws_of(d) + 1));
                chk("pslverr", 256'(pslverr[d]), 256'(e));
                if (!w) chk("prdata", 256'(prdata[d]), 256'(rd_exp));
                break;
            end
            chk("wait_pslverr", 256'(pslverr[d]), 256'(0));
            chk("wait_prdata", 256'(prdata[d]), 256'(0));
            @(negedge clk);
        end
        chk("pready_seen", 256'(seen), 256'(1));
        if (seen && w && !e) begin
            m_regs[d][a[4:2]] = wd;
            m_regs[d][7]      = m_regs[d][7] + 32'd1;
        end
        @(posedge clk);
        #1 chk("reg_out", reg_out[d], m_flat(d));
    endtask

    task automatic go_idle(input int d);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
        #1 chk("idle_pready", 256'(pready[d]), 256'(0));
    endtask

    // Write that is abandoned after n access cycles.
    task automatic abort_wr(input int d, input logic [31:0] a, input logic [31:0] wd, input int n);
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = 1'b1; pwdata[d] = wd;
        @(negedge clk);
        penable[d] = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1 chk("abort_wait_pready", 256'(pready[d]), 256'(0));
            @(negedge clk);
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        #1 chk("abort_pready", 256'(pready[d]), 256'(0));
        @(posedge clk);
        #1 chk("abort_reg_out", reg_out[d], m_flat(d));
    endtask

    // Write interrupted by reset in the cycle that would otherwise complete it.
    task automatic reset_mid_wr(input int d, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = 1'b1; pwdata[d] = wd;
        @(negedge clk);
        penable[d] = 1'b1;
        #1 chk("rst_acc1_pready", 256'(pready[d]), 256'(0));
        @(negedge clk);
        areset[d] = 1'b1;
        #1 chk("rst_pready", 256'(pready[d]), 256'(0));
        @(posedge clk);
        for (int i = 0; i < 8; i++) m_regs[d][i] = 32'h0;
        @(negedge clk);
        areset[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
        #1 chk("rst_after_pready", 256'(pready[d]), 256'(0));
        chk("rst_reg_out", reg_out[d], 256'(0));
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        total = 0;
        bad   = 0;
        for (int d = 0; d < 3; d++) begin
            areset[d] = 1'b1; paddr[d] = '0; psel[d] = 1'b0; penable[d] = 1'b0;
            pwrite[d] = 1'b0; pwdata[d] = '0;
            for (int i = 0; i < 8; i++) m_regs[d][i] = 32'h0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) areset[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_reg_out", reg_out[d], 256'(0));
            chk("rst_pready", 256'(pready[d]), 256'(0));
            chk("rst_pslverr", 256'(pslverr[d]), 256'(0));
            chk("rst_prdata", 256'(prdata[d]), 256'(0));
        end

        // Read the whole map after reset.
        for (int i = 0; i < 8; i++) xfer(0, 32'(i * 4), 1'b0, 32'h0);

        // Basic write/read and write count.
        xfer(0, 32'h04, 1'b1, 32'hDEADBEEF);
        xfer(0, 32'h04, 1'b0, 32'h0);
        chk("reg1_slice", 256'(reg_out[0][63:32]), 256'(32'hDEADBEEF));
        xfer(0, 32'h1C, 1'b0, 32'h0);
        chk("wcount_1", 256'(reg_out[0][255:224]), 256'(1));

        // Error cases.
        xfer(0, 32'h1C, 1'b1, 32'h11111111);
        xfer(0, 32'h20, 1'b1, 32'h22222222);
        xfer(0, 32'h06, 1'b1, 32'h33333333);
        xfer(0, 32'h20, 1'b0, 32'h0);
        chk("wcount_after_err", 256'(reg_out[0][255:224]), 256'(1));
        go_idle(0);

        // Four back-to-back writes on the 0 and 3 wait-state builds.
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 4; i++) xfer(d, 32'(i * 4), 1'b1, $urandom);
            xfer(d, 32'h1C, 1'b0, 32'h0);
            chk("wcount_4", 256'(reg_out[d][255:224]), 256'(4));
            go_idle(d);
        end

        // Abort after one wait cycle, then a normal transfer.
        abort_wr(0, 32'h08, 32'h12345678, 1);
        xfer(0, 32'h08, 1'b0, 32'h0);
        xfer(0, 32'h08, 1'b1, 32'hA5A5A5A5);
        xfer(0, 32'h08, 1'b0, 32'h0);
        go_idle(0);

        // Reset in the middle of a write, then recovery.
        reset_mid_wr(0, 32'h0C, 32'hCAFEF00D);
        xfer(0, 32'h1C, 1'b0, 32'h0);
        xfer(0, 32'h0C, 1'b1, 32'h0BADF00D);
        xfer(0, 32'h0C, 1'b0, 32'h0);
        go_idle(0);

        // Randomized traffic on every build.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r < 7) a = 32'($urandom_range(0, 7) * 4);
                else       a = 32'($urandom_range(0, 63));
                xfer(d, a, 1'($urandom_range(0, 1)), $urandom);
                if ($urandom_range(0, 3) == 0) go_idle(d);
            end
            go_idle(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
